ccm_aes_arb: RTL

CCM_AES_ARB -- requirements
Module: ccm_aes_arb

---
 rtl/ccm_aes_arb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ccm_aes_arb.sv
// Arbiter that shares one AES core between the CCM CTR path and the CBC-MAC path.
// Only one AES operation is in flight at a time. Simultaneous requests are
// served round-robin. Results come back through a single registered bus, and a
// per-owner strobe tells each requester when that bus holds its result.
module ccm_aes_arb #(
  parameter int WIDTH_BLK = 128,
  parameter int TIMEOUT   = 63
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ctr_req,
  input  logic [WIDTH_BLK-1:0] ctr_data,
  output logic                 ctr_gnt,
  output logic                 ctr_res_en,
  input  logic                 mac_req,
  input  logic [WIDTH_BLK-1:0] mac_data,
  output logic                 mac_gnt,
  output logic                 mac_res_en,
  output logic [WIDTH_BLK-1:0] res_data,
  output logic [WIDTH_BLK-1:0] aes_in_data,
  output logic                 aes_in_en,
  input  logic [WIDTH_BLK-1:0] aes_out_data,
  input  logic                 aes_out_en,
  output logic                 busy,
  output logic [1:0]           err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic       OWN_CTR     = 1'b0;
  localparam logic       OWN_MAC     = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             wait_cnt_q, wait_cnt_d, wait_cnt_inc;
  logic                   owner_q, owner_d;
  logic                   last_owner_q, last_owner_d;
  logic                   grant_mac;
  logic                   ctr_gnt_d, mac_gnt_d;
  logic                   ctr_res_en_d, mac_res_en_d;
  logic                   aes_in_en_d;
  logic [WIDTH_BLK-1:0]   aes_in_data_d, res_data_d;
  logic [1:0]             err_d;

  assign wait_cnt_inc = wait_cnt_q + 8'd1;

  // MAC wins when it is the only requester, or on a tie when CTR owned the core last.
  assign grant_mac = mac_req && (!ctr_req || (last_owner_q == OWN_CTR));

  assign busy = (state_q == ST_WAIT);

  // Next-state and next-output logic; every strobe defaults low so each pulse lasts one cycle.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    ctr_gnt_d     = 1'b0;
    mac_gnt_d     = 1'b0;
    ctr_res_en_d  = 1'b0;
    mac_res_en_d  = 1'b0;
    aes_in_en_d   = 1'b0;
    aes_in_data_d = aes_in_data;
    res_data_d    = res_data;
    err_d         = err;

    case (state_q)
      ST_IDLE: begin
        // Nothing is outstanding, so any AES result here is unexpected.
        if (aes_out_en) begin
          err_d[1] = 1'b1;
        end
        if (ctr_req || mac_req) begin
          state_d      = ST_WAIT;
          wait_cnt_d   = 8'd0;
          aes_in_en_d  = 1'b1;
          owner_d      = grant_mac ? OWN_MAC : OWN_CTR;
          last_owner_d = grant_mac ? OWN_MAC : OWN_CTR;
          if (grant_mac) begin
            mac_gnt_d     = 1'b1;
            aes_in_data_d = mac_data;
          end else begin
            ctr_gnt_d     = 1'b1;
            aes_in_data_d = ctr_data;
          end
        end
      end

      ST_WAIT: begin
        // A result that arrives on the same cycle as the timeout still counts as valid.
        if (aes_out_en) begin
          state_d    = ST_IDLE;
          wait_cnt_d = 8'd0;
          res_data_d = aes_out_data;
          if (owner_q == OWN_MAC) begin
            mac_res_en_d = 1'b1;
          end else begin
            ctr_res_en_d = 1'b1;
          end
        end else if (wait_cnt_inc == TIMEOUT_CNT) begin
          state_d    = ST_IDLE;
          wait_cnt_d = 8'd0;
          err_d[0]   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, bookkeeping and registered outputs; reset also clears the data buses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= 8'd0;
      owner_q      <= OWN_CTR;
      last_owner_q <= OWN_MAC;
      ctr_gnt      <= 1'b0;
      mac_gnt      <= 1'b0;
      ctr_res_en   <= 1'b0;
      mac_res_en   <= 1'b0;
      aes_in_en    <= 1'b0;
      aes_in_data  <= '0;
      res_data     <= '0;
      err          <= 2'b00;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      ctr_gnt      <= ctr_gnt_d;
      mac_gnt      <= mac_gnt_d;
      ctr_res_en   <= ctr_res_en_d;
      mac_res_en   <= mac_res_en_d;
      aes_in_en    <= aes_in_en_d;
      aes_in_data  <= aes_in_data_d;
      res_data     <= res_data_d;
      err          <= err_d;
    end
  end

endmodule
